// File: rtl/tvout_timing_gen.sv
// Composite-video raster timing and test-pattern generator for a 2-pin TV-out DAC.
// A pixel tick from a clock divider steps the x/y counters; video and sync outputs are registered.
module tvout_timing_gen #(
  parameter int CLK_DIV   = 5,
  parameter int H_TOTAL   = 640,
  parameter int V_TOTAL   = 312,
  parameter int H_ACTIVE  = 490,
  parameter int V_ACTIVE  = 268,
  parameter int HS_START  = 528,
  parameter int HS_END    = 575,
  parameter int VS_START  = 276,
  parameter int VS_END    = 279,
  parameter int INTERLACE = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] mode,
  output logic       vout,
  output logic       sync_n,
  output logic       active,
  output logic [9:0] xpos,
  output logic [8:0] ypos,
  output logic       field,
  output logic       line_start,
  output logic       frame_start
);
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [9:0] X_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] X_ACT      = 10'(H_ACTIVE);
  localparam logic [9:0] X_ACT_LAST = 10'(H_ACTIVE - 1);
  localparam logic [9:0] X_HS0      = 10'(HS_START);
  localparam logic [9:0] X_HS1      = 10'(HS_END);
  localparam logic [8:0] Y_LAST0    = 9'(V_TOTAL - 1);
  localparam logic [8:0] Y_LAST1    = 9'(V_TOTAL);
  localparam logic [8:0] Y_ACT      = 9'(V_ACTIVE);
  localparam logic [8:0] Y_ACT_LAST = 9'(V_ACTIVE - 1);
  localparam logic [8:0] Y_VS0      = 9'(VS_START);
  localparam logic [8:0] Y_VS1      = 9'(VS_END);

  if (CLK_DIV < 1 || HS_END > H_TOTAL || VS_END > V_TOTAL ||
      H_ACTIVE > H_TOTAL || V_ACTIVE > V_TOTAL) begin : g_param_check
    $error("tvout_timing_gen: illegal parameter set");
  end

  logic [DIV_W-1:0] div;
  logic [1:0]       mode_q;
  logic             tick;
  logic             x_wrap, y_wrap;
  logic [9:0]       x_next;
  logic [8:0]       y_next;
  logic             field_next;
  logic [1:0]       mode_next;
  logic             act_next, hs_next, vs_next, pat_next;

  assign tick = (div == DIV_LAST);

  // Decode from the next position so the registered video matches the registered x/y.
  always_comb begin
    x_wrap     = (xpos == X_LAST);
    y_wrap     = x_wrap && (ypos == ((INTERLACE != 0 && field) ? Y_LAST1 : Y_LAST0));
    x_next     = x_wrap ? 10'd0 : xpos + 10'd1;
    y_next     = ypos;
    if (x_wrap) y_next = y_wrap ? 9'd0 : ypos + 9'd1;
    field_next = (INTERLACE != 0) ? (field ^ y_wrap) : 1'b0;
    mode_next  = y_wrap ? mode : mode_q;
    act_next   = (x_next < X_ACT) && (y_next < Y_ACT);
    hs_next    = (x_next >= X_HS0) && (x_next < X_HS1);
    vs_next    = (y_next >= Y_VS0) && (y_next < Y_VS1);
    pat_next   = 1'b1;
    case (mode_next)
      2'd0:    pat_next = (x_next == 10'd0) || (x_next == X_ACT_LAST) ||
                          (y_next == 9'd0) || (y_next == Y_ACT_LAST);
      2'd1:    pat_next = 1'b1;
      2'd2:    pat_next = (x_next[4:0] == 5'd0) || (y_next[4:0] == 5'd0);
      default: pat_next = x_next[5] ^ y_next[5];
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div         <= '0;
      xpos        <= '0;
      ypos        <= '0;
      field       <= 1'b0;
      mode_q      <= 2'd0;
      vout        <= 1'b0;
      sync_n      <= 1'b1;
      active      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (tick) begin
        div         <= '0;
        xpos        <= x_next;
        ypos        <= y_next;
        field       <= field_next;
        mode_q      <= mode_next;
        active      <= act_next;
        sync_n      <= act_next || !(hs_next || vs_next);
        vout        <= act_next && pat_next;
        line_start  <= x_wrap;
        frame_start <= y_wrap;
      end else begin
        div <= div + DIV_ONE;
      end
    end
  end
endmodule
